// File: rtl/axis_fifo_downsizer.sv
// AXI-Stream FIFO that buffers wide slave words and serialises each one into
// S_DWIDTH/M_DWIDTH narrow master beats, with configurable beat order.
module axis_fifo_downsizer #(
    parameter int S_DWIDTH  = 32,
    parameter int M_DWIDTH  = 8,
    parameter int DEPTH     = 32,
    parameter int MSB_FIRST = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_tvalid,
    output logic                         s_tready,
    input  logic [S_DWIDTH-1:0]          s_tdata,
    input  logic                         s_tlast,
    output logic                         m_tvalid,
    input  logic                         m_tready,
    output logic [M_DWIDTH-1:0]          m_tdata,
    output logic                         m_tlast,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int RATIO  = S_DWIDTH / M_DWIDTH;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    // Moves the next slice into the output position of the shift register.
    function automatic logic [S_DWIDTH-1:0] shift_word(input logic [S_DWIDTH-1:0] w);
        if (MSB_FIRST != 0) return w << M_DWIDTH;
        else                return w >> M_DWIDTH;
    endfunction

    logic [S_DWIDTH:0] mem [DEPTH];

    state_t              state_q,  state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]    level_q,  level_d;
    logic [BEAT_W-1:0]   beat_q,   beat_d;
    logic [S_DWIDTH-1:0] word_q,   word_d;
    logic                last_q,   last_d;

    logic wr_en;
    logic pop_en;
    logic beat_done;

    assign wr_en     = s_tvalid && (level_q != FULL_LVL);
    assign beat_done = (state_q == SEND) && m_tready && (beat_q == LAST_BEAT);
    // Popping on the final beat's handshake keeps the stream bubble-free.
    assign pop_en    = (level_q != '0) && ((state_q == IDLE) || beat_done);

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        level_d  = level_q;
        case ({wr_en, pop_en})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        word_d   = word_q;
        last_d   = last_q;
        if (pop_en) begin
            word_d   = mem[rd_ptr_q][S_DWIDTH-1:0];
            last_d   = mem[rd_ptr_q][S_DWIDTH];
            beat_d   = '0;
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = SEND;
        end else if ((state_q == SEND) && m_tready) begin
            if (beat_q != LAST_BEAT) begin
                beat_d = beat_q + 1'b1;
                word_d = shift_word(word_q);
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= {s_tlast, s_tdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            beat_q   <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            beat_q   <= beat_d;
            word_q   <= word_d;
            last_q   <= last_d;
        end
    end

    assign s_tready = (level_q != FULL_LVL);
    assign level    = level_q;
    assign m_tvalid = (state_q == SEND);
    assign m_tdata  = (MSB_FIRST != 0) ? word_q[S_DWIDTH-1 -: M_DWIDTH] : word_q[M_DWIDTH-1:0];
    assign m_tlast  = (state_q == SEND) && last_q && (beat_q == LAST_BEAT);

endmodule

// File: tb/tb_axis_fifo_downsizer.sv
// Bench for axis_fifo_downsizer: an LSB-first and an MSB-first instance run in
// lockstep against a queue-based model, plus table vectors and corner sequences.
module tb_axis_fifo_downsizer;

    localparam int D  = 32;
    localparam int LW = $clog2(D + 1);

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        m_tready = 1'b0;
    logic [31:0] s_tdata = '0;

    logic          s_tready0, s_tready1, m_tvalid0, m_tvalid1, m_tlast0, m_tlast1;
    logic [7:0]    m_tdata0, m_tdata1;
    logic [LW-1:0] level0, level1;

    always #5 clk = ~clk;

    axis_fifo_downsizer #(.S_DWIDTH(32), .M_DWIDTH(8), .DEPTH(D), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready0),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .m_tvalid(m_tvalid0), .m_tready(m_tready),
        .m_tdata(m_tdata0), .m_tlast(m_tlast0), .level(level0));

    axis_fifo_downsizer #(.S_DWIDTH(32), .M_DWIDTH(8), .DEPTH(D), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst_n(rst_n), .s_tvalid(s_tvalid), .s_tready(s_tready1),
        .s_tdata(s_tdata), .s_tlast(s_tlast), .m_tvalid(m_tvalid1), .m_tready(m_tready),
        .m_tdata(m_tdata1), .m_tlast(m_tlast1), .level(level1));

    int checks = 0;
    int failures = 0;
    int run_len = 0;
    int max_run = 0;

    logic [32:0] mq[$];
    logic [8:0]  bq0[$], bq1[$];
    logic [8:0]  cap0[$], cap1[$];

    typedef struct {
        logic [31:0] word;
        logic        last;
        logic [31:0] exp_lsb;
        logic [31:0] exp_msb;
    } vec_t;
    vec_t vt[5];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Word-level model: FIFO of words plus the list of beats still owed downstream.
    task automatic model_step();
        logic wr, pop;
        logic [32:0] w;
        if (!rst_n) begin
            mq.delete(); bq0.delete(); bq1.delete();
            return;
        end
        wr  = s_tvalid && (mq.size() != D);
        pop = (mq.size() != 0) && ((bq0.size() == 0) || (m_tready && bq0.size() == 1));
        if (m_tready && bq0.size() != 0) begin
            void'(bq0.pop_front());
            void'(bq1.pop_front());
        end
        if (pop) begin
            w = mq.pop_front();
            for (int i = 0; i < 4; i++) begin
                bq0.push_back({w[32] && (i == 3), w[8*i +: 8]});
                bq1.push_back({w[32] && (i == 3), w[8*(3-i) +: 8]});
            end
        end
        if (wr) mq.push_back({s_tlast, s_tdata});
    endtask

    task automatic check_model();
        logic [16:0] e0, e1, a0, a1;
        logic [8:0]  h0, h1;
        h0 = (bq0.size() != 0) ? bq0[0] : 9'h0;
        h1 = (bq1.size() != 0) ? bq1[0] : 9'h0;
        e0 = {bq0.size() != 0, h0, LW'(mq.size()), mq.size() != D};
        e1 = {bq1.size() != 0, h1, LW'(mq.size()), mq.size() != D};
        a0 = {m_tvalid0, m_tvalid0 ? {m_tlast0, m_tdata0} : 9'h0, level0, s_tready0};
        a1 = {m_tvalid1, m_tvalid1 ? {m_tlast1, m_tdata1} : 9'h0, level1, s_tready1};
        check("model_lsb{vld,last,data,lvl,rdy}", 64'(a0), 64'(e0));
        check("model_msb{vld,last,data,lvl,rdy}", 64'(a1), 64'(e1));
    endtask

    task automatic cycle();
        if (m_tvalid0 && m_tready) cap0.push_back({m_tlast0, m_tdata0});
        if (m_tvalid1 && m_tready) cap1.push_back({m_tlast1, m_tdata1});
        @(posedge clk);
        model_step();
        #1;
        check_model();
        if (m_tvalid0) run_len++; else run_len = 0;
        if (run_len > max_run) max_run = run_len;
    endtask

    task automatic put_word(input logic [31:0] w, input logic l);
        s_tvalid = 1'b1; s_tdata = w; s_tlast = l;
        cycle();
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        m_tready = 1'b1;
        for (int k = 0; k < 400 && (mq.size() != 0 || bq0.size() != 0); k++) cycle();
        check(name, 64'(mq.size() + bq0.size()), 64'd0);
    endtask

    initial begin
        int acc;
        int sent;
        logic [31:0] nxt;
        logic ok;

        vt[0] = '{32'hA1B2C3D4, 1'b1, 32'hD4C3B2A1, 32'hA1B2C3D4};
        vt[1] = '{32'h11223344, 1'b0, 32'h44332211, 32'h11223344};
        vt[2] = '{32'h00000000, 1'b1, 32'h00000000, 32'h00000000};
        vt[3] = '{32'h5A00FF81, 1'b0, 32'h81FF005A, 32'h5A00FF81};
        vt[4] = '{32'h03020100, 1'b1, 32'h00010203, 32'h03020100};

        #2 rst_n = 1'b0;
        #1;
        check("rst_vld", 64'({m_tvalid0, m_tvalid1}), 64'd0);
        check("rst_data", 64'({m_tdata0, m_tdata1}), 64'd0);
        check("rst_last", 64'({m_tlast0, m_tlast1}), 64'd0);
        check("rst_level", 64'({level0, level1}), 64'd0);
        check("rst_ready", 64'({s_tready0, s_tready1}), 64'b11);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();

        // Single words through both beat orders, with latency checks.
        for (int v = 0; v < 5; v++) begin
            cap0.delete(); cap1.delete();
            m_tready = 1'b1;
            put_word(vt[v].word, vt[v].last);
            check("lat_after_accept_vld", 64'(m_tvalid0), 64'd0);
            check("lat_after_accept_lvl", 64'(level0), 64'd1);
            cycle();
            check("lat_after_load_vld", 64'(m_tvalid0), 64'd1);
            for (int k = 0; k < 20 && cap0.size() < 4; k++) cycle();
            check("vec_beats_lsb", 64'(cap0.size()), 64'd4);
            check("vec_beats_msb", 64'(cap1.size()), 64'd4);
            for (int i = 0; i < 4 && i < cap0.size() && i < cap1.size(); i++) begin
                check("vec_lsb_beat", 64'(cap0[i]), 64'({vt[v].last && (i == 3), vt[v].exp_lsb[31-8*i -: 8]}));
                check("vec_msb_beat", 64'(cap1[i]), 64'({vt[v].last && (i == 3), vt[v].exp_msb[31-8*i -: 8]}));
            end
        end

        // Fill with the consumer stalled: DEPTH in the FIFO plus one in the output stage.
        m_tready = 1'b0;
        acc = 0;
        nxt = 32'h0000_1000;
        for (int k = 0; k < 40; k++) begin
            s_tvalid = 1'b1; s_tdata = nxt; s_tlast = nxt[0];
            if (s_tready0) begin
                acc++;
                nxt++;
            end
            cycle();
        end
        s_tvalid = 1'b0;
        check("full_accepted", 64'(acc), 64'd33);
        check("full_level", 64'(level0), 64'd32);
        check("full_ready", 64'(s_tready0), 64'd0);
        m_tready = 1'b1;
        repeat (4) cycle();
        check("after_one_word_ready", 64'(s_tready0), 64'd1);
        check("after_one_word_level", 64'(level0), 64'd31);
        drain("full_drain");

        // Consumer ready toggling every cycle across two words.
        cap0.delete(); cap1.delete();
        for (int k = 0; k < 60; k++) begin
            if (k == 0) begin s_tvalid = 1'b1; s_tdata = 32'h03020100; s_tlast = 1'b0; end
            if (k == 1) begin s_tvalid = 1'b1; s_tdata = 32'h07060504; s_tlast = 1'b1; end
            if (k == 2) s_tvalid = 1'b0;
            m_tready = (k % 2) == 1;
            cycle();
            if (k >= 2 && cap0.size() >= 8) break;
        end
        s_tvalid = 1'b0;
        check("toggle_beats", 64'(cap0.size()), 64'd8);
        for (int i = 0; i < 8 && i < cap0.size() && i < cap1.size(); i++) begin
            check("toggle_lsb_beat", 64'(cap0[i]), 64'({i == 7, 8'(i)}));
            check("toggle_msb_beat", 64'(cap1[i]), 64'({i == 7, 8'((i < 4) ? 3 - i : 11 - i)}));
        end
        drain("toggle_drain");

        // Back-to-back words must stream without a bubble.
        m_tready = 1'b1;
        cycle();
        run_len = 0; max_run = 0;
        for (int k = 0; k < 4; k++) begin
            s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = 1'($urandom_range(1));
            cycle();
        end
        s_tvalid = 1'b0;
        repeat (25) cycle();
        check("b2b_valid_run", 64'(max_run), 64'd16);

        // Randomised traffic long enough to wrap both pointers several times.
        sent = 0;
        for (int k = 0; k < 3000 && sent < 80; k++) begin
            if (!s_tvalid && $urandom_range(3) != 0) begin
                s_tvalid = 1'b1; s_tdata = $urandom; s_tlast = 1'($urandom_range(1));
            end
            m_tready = $urandom_range(3) != 0;
            ok = s_tvalid && s_tready0;
            cycle();
            if (ok) begin
                sent++;
                s_tvalid = 1'b0;
            end
        end
        s_tvalid = 1'b0;
        check("rand_sent", 64'(sent), 64'd80);
        drain("rand_drain");

        // Reset in the middle of a word with more words queued.
        m_tready = 1'b0;
        for (int k = 0; k < 6; k++) put_word(32'hC0DE_0000 + 32'(k), 1'b1);
        cycle();
        check("midrst_queued", 64'(level0), 64'd5);
        cap0.delete(); cap1.delete();
        m_tready = 1'b1;
        for (int k = 0; k < 10 && cap0.size() < 2; k++) cycle();
        check("midrst_two_beats", 64'(cap0.size()), 64'd2);
        rst_n = 1'b0;
        #1;
        check("midrst_vld", 64'({m_tvalid0, m_tvalid1}), 64'd0);
        check("midrst_level", 64'({level0, level1}), 64'd0);
        check("midrst_data", 64'({m_tdata0, m_tdata1}), 64'd0);
        cycle(); cycle();
        rst_n = 1'b1;
        cycle();
        cap0.delete(); cap1.delete();
        put_word(32'h11223344, 1'b1);
        repeat (15) cycle();
        check("postrst_beats_lsb", 64'(cap0.size()), 64'd4);
        check("postrst_beats_msb", 64'(cap1.size()), 64'd4);
        for (int i = 0; i < 4 && i < cap0.size() && i < cap1.size(); i++) begin
            check("postrst_lsb", 64'(cap0[i]), 64'({i == 3, 8'(8'h44 - 8'(i) * 8'h11)}));
            check("postrst_msb", 64'(cap1[i]), 64'({i == 3, 8'(8'h11 + 8'(i) * 8'h11)}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_fifo_downsizer.md
Name: axis_fifo_downsizer

Overview:
AXI-Stream buffer and width downsizer in one block. It is the parametrised successor of the fixed 32-bit FIFO plus 32-to-8 stream adapter pair. Wide words arrive on the slave port and are stored in an internal FIFO. Each word is serialised into RATIO = S_DWIDTH/M_DWIDTH narrow beats on the master port, with selectable beat order, tlast propagation and a fill-level output. It sits between a wide producer and a narrow consumer.

Parameters:
- S_DWIDTH, 32, slave data width; must be an integer multiple of M_DWIDTH.
- M_DWIDTH, 8, master data width.
- DEPTH, 32, FIFO depth in slave words; power of two, at least 2.
- MSB_FIRST, 0, beat order. 0: bits [M_DWIDTH-1:0] are sent first. 1: the most significant slice is sent first.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- s_tvalid  in  1  slave word valid.
- s_tready  out  1  slave ready; equals (level != DEPTH).
- s_tdata  in  S_DWIDTH  slave word.
- s_tlast  in  1  word ends a packet.
- m_tvalid  out  1  master beat valid.
- m_tready  in  1  master ready.
- m_tdata  out  M_DWIDTH  master beat.
- m_tlast  out  1  last beat of a word that carried s_tlast=1.
- level  out  $clog2(DEPTH+1)  words held in the FIFO; excludes the output stage.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Pointers and level go to 0; beat counter goes to 0.
  - m_tvalid=0, m_tdata=0, m_tlast=0; output stage is empty.
  - s_tready=1 while in reset; upstream must hold s_tvalid=0 during reset.
- Write:
  - Occurs on an edge where s_tvalid && s_tready.
  - Stores {s_tlast, s_tdata} at wr_ptr; wr_ptr wraps modulo DEPTH.
  - No write while full, even if a read happens on the same edge.
- Output stage, two states:
  - IDLE: m_tvalid=0. On an edge where level != 0, pop one word into the shift register, set beat=0, go to SEND.
  - SEND: m_tvalid=1. m_tdata is slice beat, in MSB_FIRST order. m_tlast = stored_last && (beat == RATIO-1).
  - SEND, edge with m_tready=1 and beat < RATIO-1: beat increments.
  - SEND, edge with m_tready=1 and beat == RATIO-1: if level != 0, pop the next word on that same edge (no bubble) and stay in SEND; else go to IDLE.
  - SEND, m_tready=0: m_tdata and m_tlast hold stable; m_tvalid stays 1.
- Latency:
  - Word accepted on edge E: level updates at E; output stage loads at E+1; m_tvalid=1 after E+1.
  - Throughput: one beat per cycle sustained.
- level:
  - +1 on a write edge, -1 on a pop edge, unchanged when both occur.
  - Maximum occupancy is DEPTH + 1 words (DEPTH in the FIFO plus one in the output stage).
- RATIO=1: pass-through with FIFO; every beat is the last beat of its word.
- Reset mid-word: the partial word and all FIFO contents are discarded, with no residual beats after release.
- Pointer wrap: must be exercised; level is tracked explicitly, so full and empty are unambiguous.

Test Plan:
- Defaults, one word 0xA1B2C3D4 with tlast=1, m_tready=1 -> beats D4, C3, B2, A1; m_tlast=1 only on A1; m_tvalid rises after second edge from acceptance.
- MSB_FIRST=1, same word -> beats A1, B2, C3, D4; m_tlast on D4.
- m_tready=0, offer 40 words -> exactly 33 accepted; level=32; s_tready=0; after draining 1 word, s_tready=1 again.
- m_tready toggled every cycle, words 0x03020100 and 0x07060504 with tlast=0,1 -> beats 00..07 in order; no drop or duplicate; data stable on stalls; m_tlast only on 07.
- m_tready=1, 4 words written back-to-back -> m_tvalid high for 16 consecutive cycles; then 80 words streamed to cover pointer wrap, with data matched by a scoreboard.
- rst_n low after beat 2 of a word, with 5 words queued -> m_tvalid=0 and level=0 immediately; after release, a new word 0x11223344 yields only 44, 33, 22, 11.
